s9io_fifo_irq: RTL and testbench

- Parametrised synchronous FIFO with register-level control and status semantics. It is the successor of the fixed-function command/work FIFOs in the S9 board interface core.
- One instance serves either a receive-direction FIFO or a transmit-direction FIFO, selected by parameter.
- Provides: soft clear, level-threshold interrupt with enable, full/empty/irq-pending status, and a saturating error counter for overflow/underflow attempts.
- Sits between the AXI register decoder and the UART work/command framing logic.

---
 rtl/s9io_fifo_irq.sv | 128 ++++++++++++
 tb/tb_s9io_fifo_irq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/s9io_fifo_irq.sv
// Synchronous FWFT FIFO with soft clear, level-threshold interrupt and a saturating
// overflow/underflow error counter.
module s9io_fifo_irq #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 7,
  parameter int unsigned IRQ_MODE   = 0,
  parameter int unsigned ERR_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_ready,
  input  logic                  irq_en,
  input  logic [DEPTH_LOG2:0]   irq_thr,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  irq_pend,
  output logic                  irq,
  input  logic                  err_clr,
  output logic [ERR_WIDTH-1:0]  err_cnt
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned LvlW  = DEPTH_LOG2 + 1;
  localparam int unsigned SumW  = ERR_WIDTH + 1;
  localparam logic [DEPTH_LOG2:0]  LevelFull = LvlW'(Depth);
  localparam logic [ERR_WIDTH-1:0] ErrMax    = '1;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  irq_pend_q, irq_pend_d;
  logic                  irq_q, irq_d;
  logic [ERR_WIDTH-1:0]  err_q, err_d;
  logic [SumW-1:0]       err_sum;
  logic                  wr_acc, rd_acc, ovf, udf;

  // Flags come from registered level only: no full or empty bypass.
  assign full     = (level_q == LevelFull);
  assign empty    = (level_q == '0);
  assign wr_ready = ~full;
  assign rd_valid = ~empty;
  assign rd_data  = mem_q[rd_ptr_q];
  assign level    = level_q;
  assign irq_pend = irq_pend_q;
  assign irq      = irq_q;
  assign err_cnt  = err_q;

  assign wr_acc = wr_valid & ~full & ~clear;
  assign rd_acc = rd_ready & ~empty & ~clear;
  assign ovf    = wr_valid & full & ~clear;
  assign udf    = rd_ready & empty & ~clear;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + LvlW'(1);
        2'b01:   level_d = level_q - LvlW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Pending is evaluated on next-state level so it lines up with the level register.
  always_comb begin
    irq_pend_d = 1'b0;
    if (IRQ_MODE == 1) begin
      irq_pend_d = (level_d < irq_thr);
    end else begin
      irq_pend_d = (irq_thr != '0) && (level_d >= irq_thr);
    end
    irq_d = irq_pend_d & irq_en;
  end

  // One extra bit absorbs a +2 step so saturation is a simple compare.
  always_comb begin
    err_sum = {1'b0, err_q} + SumW'(ovf) + SumW'(udf);
    err_d   = err_q;
    if (err_clr) begin
      err_d = '0;
    end else if (err_sum > {1'b0, ErrMax}) begin
      err_d = ErrMax;
    end else begin
      err_d = err_sum[ERR_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      irq_pend_q <= 1'b0;
      irq_q      <= 1'b0;
      err_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      irq_pend_q <= irq_pend_d;
      irq_q      <= irq_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_s9io_fifo_irq.sv
// Directed bench: an RX-style 16-deep instance with a wide error counter and a TX-style
// instance with a 2-bit error counter, sharing stimulus; a queue holds expected read data.
module tb_s9io_fifo_irq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic        rd_ready = 1'b0;
  logic        irq_en = 1'b1;
  logic [4:0]  irq_thr0 = 5'd4;
  logic [4:0]  irq_thr1 = 5'd3;
  logic        err_clr = 1'b0;

  logic        wr_ready0, rd_valid0, full0, empty0, irq_pend0, irq0;
  logic [31:0] rd_data0;
  logic [4:0]  level0;
  logic [15:0] err0;
  logic        wr_ready1, rd_valid1, full1, empty1, irq_pend1, irq1;
  logic [31:0] rd_data1;
  logic [4:0]  level1;
  logic [1:0]  err1;

  int total = 0;
  int bad = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_word;
  int lvl;

  always #5 clk = ~clk;

  s9io_fifo_irq #(.DATA_WIDTH(32), .DEPTH_LOG2(4), .IRQ_MODE(0), .ERR_WIDTH(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready0), .rd_valid(rd_valid0), .rd_data(rd_data0), .rd_ready(rd_ready),
    .irq_en(irq_en), .irq_thr(irq_thr0), .level(level0), .full(full0), .empty(empty0),
    .irq_pend(irq_pend0), .irq(irq0), .err_clr(err_clr), .err_cnt(err0)
  );

  s9io_fifo_irq #(.DATA_WIDTH(32), .DEPTH_LOG2(4), .IRQ_MODE(1), .ERR_WIDTH(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready1), .rd_valid(rd_valid1), .rd_data(rd_data1), .rd_ready(rd_ready),
    .irq_en(irq_en), .irq_thr(irq_thr1), .level(level1), .full(full1), .empty(empty1),
    .irq_pend(irq_pend1), .irq(irq1), .err_clr(err_clr), .err_cnt(err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state();
    chk("rst_level0", 32'(level0), 32'd0);
    chk("rst_empty0", 32'(empty0), 32'd1);
    chk("rst_full0", 32'(full0), 32'd0);
    chk("rst_wr_ready0", 32'(wr_ready0), 32'd1);
    chk("rst_rd_valid0", 32'(rd_valid0), 32'd0);
    chk("rst_irq_pend0", 32'(irq_pend0), 32'd0);
    chk("rst_irq0", 32'(irq0), 32'd0);
    chk("rst_err0", 32'(err0), 32'd0);
    chk("rst_irq_pend1", 32'(irq_pend1), 32'd0);
    chk("rst_err1", 32'(err1), 32'd0);
  endtask

  initial begin
    // Reset applied through the first clock edge.
    step();
    chk_reset_state();
    rst_n = 1'b1;
    step();
    // TX-style instance pends at the first edge after release; RX-style does not.
    chk("tx_irq_pend_after_rst", 32'(irq_pend1), 32'd1);
    chk("tx_irq_after_rst", 32'(irq1), 32'd1);
    chk("rx_irq_pend_idle", 32'(irq_pend0), 32'd0);
    irq_en = 1'b0;
    step();
    chk("tx_irq_masked", 32'(irq1), 32'd0);
    chk("tx_pend_while_masked", 32'(irq_pend1), 32'd1);
    irq_en = 1'b1;

    // Fill 16 words.
    wr_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 32'h10 + 32'(i);
      sb.push_back(wr_data);
      step();
      chk("fill_level", 32'(level0), 32'(i + 1));
      if (i == 2) chk("tx_pend_at_thr", 32'(irq_pend1), 32'd0);
      if (i == 2) chk("rx_pend_below_thr", 32'(irq_pend0), 32'd0);
      if (i == 3) chk("rx_pend_at_thr", 32'(irq_pend0), 32'd1);
      if (i == 3) chk("rx_irq_at_thr", 32'(irq0), 32'd1);
    end
    chk("full_flag", 32'(full0), 32'd1);
    chk("wr_ready_full", 32'(wr_ready0), 32'd0);
    wr_data = 32'h99;
    step();
    chk("ovf_level", 32'(level0), 32'd16);
    chk("ovf_err", 32'(err0), 32'd1);
    chk("ovf_full", 32'(full0), 32'd1);

    // Full: read and write together; write rejected first, then both accepted.
    rd_ready = 1'b1;
    wr_data = 32'hAA;
    exp_word = sb.pop_front();
    chk("rw_full_rd_data", rd_data0, exp_word);
    step();
    chk("rw_full_level", 32'(level0), 32'd15);
    chk("rw_full_err", 32'(err0), 32'd2);
    wr_data = 32'hAB;
    sb.push_back(wr_data);
    exp_word = sb.pop_front();
    chk("rw_both_rd_data", rd_data0, exp_word);
    step();
    chk("rw_both_level", 32'(level0), 32'd15);
    chk("rw_both_err", 32'(err0), 32'd2);

    // Drain; interrupt tracks level >= 4.
    wr_valid = 1'b0;
    lvl = 15;
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      exp_word = sb.pop_front();
      chk("drain_rd_data", rd_data0, exp_word);
      step();
      lvl--;
      chk("drain_level", 32'(level0), 32'(lvl));
      chk("drain_irq_pend", 32'(irq_pend0), 32'(lvl >= 4));
      chk("drain_irq", 32'(irq0), 32'(lvl >= 4));
    end
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    rd_ready = 1'b0;
    chk("drain_empty", 32'(empty0), 32'd1);
    chk("drain_rd_valid", 32'(rd_valid0), 32'd0);
    chk("drain_err", 32'(err0), 32'd2);

    // Zero threshold disables the RX interrupt.
    irq_thr0 = 5'd0;
    wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 32'h40 + 32'(i);
      step();
      chk("thr0_irq_pend", 32'(irq_pend0), 32'd0);
      chk("thr0_irq", 32'(irq0), 32'd0);
    end
    chk("pre_clear_level", 32'(level0), 32'd5);

    // Clear with a same-cycle write.
    clear = 1'b1;
    wr_data = 32'h55;
    step();
    clear = 1'b0;
    wr_valid = 1'b0;
    chk("clear_level", 32'(level0), 32'd0);
    chk("clear_empty", 32'(empty0), 32'd1);
    chk("clear_err", 32'(err0), 32'd2);
    chk("clear_tx_pend", 32'(irq_pend1), 32'd1);
    step();
    chk("clear_write_dropped", 32'(rd_valid0), 32'd0);

    // Error counter saturation and clear priority.
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_clr0", 32'(err0), 32'd0);
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("udf_err_wide", 32'(err0), 32'd5);
    chk("udf_err_sat", 32'(err1), 32'd3);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_clr_wins1", 32'(err1), 32'd0);
    chk("err_clr_wins0", 32'(err0), 32'd0);
    step();
    rd_ready = 1'b0;
    chk("udf_after_clr", 32'(err0), 32'd1);

    // Async reset mid-burst.
    irq_thr0 = 5'd2;
    wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 32'h70 + 32'(i);
      step();
    end
    chk("burst_level", 32'(level0), 32'd3);
    chk("burst_irq", 32'(irq0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state();
    wr_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_empty", 32'(empty0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
